// File: rtl/ddr_axi_read_master.sv
`default_nettype none
// ============================================================================
// Module : ddr_axi_read_master
// Brief  : AXI4 read master draining committed bursts from a DDR ring buffer
//          into the read FIFO, one burst outstanding at a time.
// Rev    : 1.0  initial release
// ============================================================================
module ddr_axi_read_master #(
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int BURST_LEN = 16,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int REGION_BURSTS = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          DDR_rd_en,
  input  logic                          wr_burst_done,
  input  logic                          fifo_full,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] wr_dataIn,
  output logic                          wr_dataIn_valid,
  output logic [15:0]                   avail_bursts,
  output logic [2:0]                    err
);

  localparam int c_beat_bytes = C_M_AXI_DATA_WIDTH / 8;
  localparam int c_slot_w     = (REGION_BURSTS > 1) ? $clog2(REGION_BURSTS) : 1;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] c_burst_bytes =
    C_M_AXI_ADDR_WIDTH'(BURST_LEN * c_beat_bytes);
  localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(REGION_BURSTS - 1);
  localparam logic [8:0]          c_beats     = 9'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_arvalid;
  logic                  w_rready;
  logic                  w_ar_hs;
  logic                  w_beat_acc;
  logic [c_slot_w-1:0]   r_rd_slot;
  logic [8:0]            r_beat_cnt;
  logic [8:0]            w_beat_cnt_inc;
  logic [15:0]           r_avail;
  logic [2:0]            r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (DDR_rd_en && (r_avail != 16'd0)) begin
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        w_arvalid = 1'b1;
        if (m_axi_arready) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_rready = ~fifo_full;
        if (w_rready && m_axi_rvalid && m_axi_rlast) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_ar_hs        = w_arvalid & m_axi_arready;
  assign w_beat_acc     = w_rready & m_axi_rvalid;
  assign w_beat_cnt_inc = r_beat_cnt + 9'd1;

  // Slot counter, beat counter, burst credit and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_slot  <= '0;
      r_beat_cnt <= 9'd0;
      r_avail    <= 16'd0;
      r_err      <= 3'b000;
    end else begin
      if (w_ar_hs) begin
        r_rd_slot <= (r_rd_slot == c_slot_last) ? '0 : r_rd_slot + 1'b1;
      end
      if (w_beat_acc) begin
        if (m_axi_rresp != 2'b00) begin
          r_err[0] <= 1'b1;
        end
        if (m_axi_rlast) begin
          r_beat_cnt <= 9'd0;
          if (w_beat_cnt_inc != c_beats) begin
            r_err[1] <= 1'b1;
          end
        end else begin
          if (w_beat_cnt_inc == c_beats) begin
            r_err[1] <= 1'b1;
          end
          // Saturate so an endless burst cannot alias back onto BURST_LEN
          if (r_beat_cnt != 9'h1FF) begin
            r_beat_cnt <= w_beat_cnt_inc;
          end
        end
      end
      if (wr_burst_done && !w_ar_hs) begin
        if (r_avail == 16'hFFFF) begin
          r_err[2] <= 1'b1;
        end else begin
          r_avail <= r_avail + 16'd1;
        end
      end else if (w_ar_hs && !wr_burst_done) begin
        r_avail <= r_avail - 16'd1;
      end
    end
  end

  assign m_axi_araddr    = BASE_ADDR + (C_M_AXI_ADDR_WIDTH'(r_rd_slot) * c_burst_bytes);
  assign m_axi_arlen     = 8'(BURST_LEN - 1);
  assign m_axi_arsize    = 3'($clog2(c_beat_bytes));
  assign m_axi_arburst   = 2'b01;
  assign m_axi_arvalid   = w_arvalid;
  assign m_axi_rready    = w_rready;
  assign wr_dataIn       = m_axi_rdata;
  assign wr_dataIn_valid = w_beat_acc;
  assign avail_bursts    = r_avail;
  assign err             = r_err;

endmodule
`default_nettype wire
